// File: rtl/input_vc_unit_pkg.sv
// Shared NoC parameters and sizing helpers for the router input port.
package input_vc_unit_pkg;

  localparam int unsigned DATA_WIDTH_DEF = 32;
  localparam int unsigned NUM_VC_DEF     = 2;

  // Ceiling log2; clog2(1) = 0.
  function automatic int unsigned clog2(input int unsigned n);
    int unsigned r;
    r = 0;
    while ((64'(1) << r) < 64'(n)) begin
      r = r + 1;
    end
    return r;
  endfunction

  // VC id width, never narrower than one bit.
  function automatic int unsigned vc_id_w(input int unsigned num_vc);
    return (num_vc > 1) ? clog2(num_vc) : 1;
  endfunction

endpackage

// File: rtl/input_vc_unit_if.sv
// Link-side write, allocator-side read and status bundle of one router input port.
interface input_vc_unit_if
  import input_vc_unit_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int unsigned NUM_VC     = NUM_VC_DEF
);
  localparam int unsigned VC_W = vc_id_w(NUM_VC);

  logic                  in_valid;
  logic [VC_W-1:0]       in_vc;
  logic [DATA_WIDTH-1:0] in_data;
  logic                  rd_en;
  logic [VC_W-1:0]       rd_vc;
  logic                  out_stall;

  logic [DATA_WIDTH-1:0] data_out;
  logic                  data_valid;
  logic [VC_W-1:0]       data_vc;
  logic                  credit_valid;
  logic [VC_W-1:0]       credit_vc;
  logic [NUM_VC-1:0]     full;
  logic [NUM_VC-1:0]     almost_full;
  logic [NUM_VC-1:0]     empty;
  logic [NUM_VC-1:0]     almost_empty;
  logic                  overflow_err;

  modport master (
    output in_valid, in_vc, in_data, rd_en, rd_vc, out_stall,
    input  data_out, data_valid, data_vc, credit_valid, credit_vc,
           full, almost_full, empty, almost_empty, overflow_err
  );

  modport slave (
    input  in_valid, in_vc, in_data, rd_en, rd_vc, out_stall,
    output data_out, data_valid, data_vc, credit_valid, credit_vc,
           full, almost_full, empty, almost_empty, overflow_err
  );
endinterface

// File: rtl/input_vc_unit_vc_fifo.sv
// Single-VC synchronous FIFO with a show-ahead head and count-derived status.
module vc_fifo
  import input_vc_unit_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int unsigned DEPTH      = 8,
  parameter int unsigned AFULL_TH   = 1,
  parameter int unsigned AEMPTY_TH  = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  push,
  input  logic                  pop,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic [DATA_WIDTH-1:0] head,
  output logic                  full,
  output logic                  almost_full,
  output logic                  empty,
  output logic                  almost_empty
);
  localparam int unsigned PTR_W = clog2(DEPTH);
  localparam int unsigned CNT_W = clog2(DEPTH + 1);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0]      wr_ptr;
  logic [PTR_W-1:0]      rd_ptr;
  logic [CNT_W-1:0]      count;

  // Storage needs no reset; the pointers define what is valid.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wdata;
  end

  // Pointers wrap explicitly so non-power-of-two depths work.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= (wr_ptr == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= (rd_ptr == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  assign head         = mem[rd_ptr];
  assign empty        = (count == '0);
  assign full         = (count == CNT_W'(DEPTH));
  assign almost_full  = ((DEPTH - 32'(count)) <= AFULL_TH);
  assign almost_empty = (32'(count) <= AEMPTY_TH);

endmodule

// File: rtl/input_vc_unit.sv
// Router input port: per-VC FIFOs, registered output stage with stall-hold, credit return.
module input_vc_unit
  import input_vc_unit_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int unsigned DEPTH      = 8,
  parameter int unsigned NUM_VC     = NUM_VC_DEF,
  parameter int unsigned AFULL_TH   = 1,
  parameter int unsigned AEMPTY_TH  = 1
) (
  input logic            clk,
  input logic            rst_n,
  input_vc_unit_if.slave bus
);
  localparam int unsigned VC_W = vc_id_w(NUM_VC);

  logic [NUM_VC-1:0]     wr_dec, rd_dec, push_req, push, pop;
  logic [NUM_VC-1:0]     full_v, afull_v, empty_v, aempty_v;
  logic [DATA_WIDTH-1:0] head [NUM_VC];
  logic [DATA_WIDTH-1:0] head_sel;
  logic                  pop_any, ovf;

  logic [DATA_WIDTH-1:0] data_q;
  logic                  valid_q;
  logic [VC_W-1:0]       vc_q;
  logic                  credit_q;
  logic [VC_W-1:0]       credit_vc_q;
  logic                  ovf_q;

  // Out-of-range VC ids decode to no lane, so they neither write nor pop.
  for (genvar v = 0; v < NUM_VC; v++) begin : g_vc
    assign wr_dec[v] = (bus.in_vc == VC_W'(v));
    assign rd_dec[v] = (bus.rd_vc == VC_W'(v));

    vc_fifo #(
      .DATA_WIDTH (DATA_WIDTH),
      .DEPTH      (DEPTH),
      .AFULL_TH   (AFULL_TH),
      .AEMPTY_TH  (AEMPTY_TH)
    ) u_fifo (
      .clk          (clk),
      .rst_n        (rst_n),
      .push         (push[v]),
      .pop          (pop[v]),
      .wdata        (bus.in_data),
      .head         (head[v]),
      .full         (full_v[v]),
      .almost_full  (afull_v[v]),
      .empty        (empty_v[v]),
      .almost_empty (aempty_v[v])
    );
  end

  // A full VC still accepts a write when the same VC is popped this cycle.
  always_comb begin
    head_sel = '0;
    for (int v = 0; v < NUM_VC; v++) begin
      if (rd_dec[v]) head_sel = head[v];
    end
    pop      = rd_dec & ~empty_v & {NUM_VC{bus.rd_en & ~bus.out_stall}};
    push_req = wr_dec & {NUM_VC{bus.in_valid}};
    push     = push_req & (~full_v | pop);
    pop_any  = |pop;
    ovf      = |(push_req & full_v & ~pop);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q      <= '0;
      valid_q     <= 1'b0;
      vc_q        <= '0;
      credit_q    <= 1'b0;
      credit_vc_q <= '0;
      ovf_q       <= 1'b0;
    end else begin
      if (!bus.out_stall) begin
        if (pop_any) begin
          data_q  <= head_sel;
          valid_q <= 1'b1;
          vc_q    <= bus.rd_vc;
        end else begin
          valid_q <= 1'b0;
        end
      end
      credit_q <= pop_any;
      if (pop_any) credit_vc_q <= bus.rd_vc;
      if (ovf) ovf_q <= 1'b1;
    end
  end

  assign bus.data_out     = data_q;
  assign bus.data_valid   = valid_q;
  assign bus.data_vc      = vc_q;
  assign bus.credit_valid = credit_q;
  assign bus.credit_vc    = credit_vc_q;
  assign bus.overflow_err = ovf_q;
  assign bus.full         = full_v;
  assign bus.almost_full  = afull_v;
  assign bus.empty        = empty_v;
  assign bus.almost_empty = aempty_v;

endmodule
